// File: rtl/nts_api_arbiter_if.sv
// Bundle of the two requester ports and the downstream API port of nts_api_arbiter.
// The slave modport is the arbiter's view; master is the requester/downstream side.
`timescale 1ns/1ps
interface nts_api_arbiter_if;
    logic        i_req0_cs;
    logic        i_req0_we;
    logic [11:0] i_req0_address;
    logic [31:0] i_req0_write_data;
    logic        o_req0_ack;
    logic [31:0] o_req0_read_data;
    logic        o_req0_error;

    logic        i_req1_cs;
    logic        i_req1_we;
    logic [11:0] i_req1_address;
    logic [31:0] i_req1_write_data;
    logic        o_req1_ack;
    logic [31:0] o_req1_read_data;
    logic        o_req1_error;

    logic        o_api_cs;
    logic        o_api_we;
    logic [11:0] o_api_address;
    logic [31:0] o_api_write_data;
    logic [31:0] i_api_read_data;
    logic        i_api_read_data_valid;
    logic        i_api_busy;

    logic        o_busy;

    modport slave (
        input  i_req0_cs, i_req0_we, i_req0_address, i_req0_write_data,
        output o_req0_ack, o_req0_read_data, o_req0_error,
        input  i_req1_cs, i_req1_we, i_req1_address, i_req1_write_data,
        output o_req1_ack, o_req1_read_data, o_req1_error,
        output o_api_cs, o_api_we, o_api_address, o_api_write_data,
        input  i_api_read_data, i_api_read_data_valid, i_api_busy,
        output o_busy
    );

    modport master (
        output i_req0_cs, i_req0_we, i_req0_address, i_req0_write_data,
        input  o_req0_ack, o_req0_read_data, o_req0_error,
        output i_req1_cs, i_req1_we, i_req1_address, i_req1_write_data,
        input  o_req1_ack, o_req1_read_data, o_req1_error,
        input  o_api_cs, o_api_we, o_api_address, o_api_write_data,
        output i_api_read_data, i_api_read_data_valid, i_api_busy,
        input  o_busy
    );
endinterface

// File: rtl/nts_api_arbiter.sv
// Two-requester round-robin arbiter in front of a single downstream API port,
// with per-transaction timeout that returns TIMEOUT_DATA and flags an error.
`timescale 1ns/1ps
module nts_api_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                i_clk,
    input  logic                i_areset,
    nts_api_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Counter value seen during the last permitted WAIT cycle.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_r;
    logic        prio_r;
    logic        grant_r;
    logic [15:0] cnt_r;
    logic        seen_r;
    logic [31:0] cap_data_r;

    logic        api_cs_r;
    logic        api_we_r;
    logic [11:0] api_addr_r;
    logic [31:0] api_wdata_r;
    logic        ack0_r;
    logic        ack1_r;
    logic [31:0] rdata0_r;
    logic [31:0] rdata1_r;
    logic        err0_r;
    logic        err1_r;
    logic        busy_r;

    logic        req_any_s;
    logic        grant_s;
    logic        we_s;
    logic [11:0] addr_s;
    logic [31:0] wdata_s;
    logic        seen_s;
    logic [31:0] rdata_s;
    logic        done_s;
    logic        tmo_s;
    logic [31:0] resp_data_s;
    logic        resp_err_s;

    // Round-robin grant and granted-command select for the IDLE state.
    always_comb begin
        req_any_s = bus.i_req0_cs | bus.i_req1_cs;
        if (bus.i_req0_cs && bus.i_req1_cs) begin
            grant_s = prio_r;
        end else if (bus.i_req1_cs) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            we_s    = bus.i_req1_we;
            addr_s  = bus.i_req1_address;
            wdata_s = bus.i_req1_write_data;
        end else begin
            we_s    = bus.i_req0_we;
            addr_s  = bus.i_req0_address;
            wdata_s = bus.i_req0_write_data;
        end
    end

    // WAIT-state completion decode; a valid pulse in the exit cycle counts immediately.
    always_comb begin
        seen_s = seen_r | bus.i_api_read_data_valid;
        if (bus.i_api_read_data_valid) begin
            rdata_s = bus.i_api_read_data;
        end else begin
            rdata_s = cap_data_r;
        end
        done_s = ~bus.i_api_busy & (api_we_r | seen_s);
        tmo_s  = (cnt_r == TMO_LAST);
        if (done_s) begin
            if (api_we_r) begin
                resp_data_s = 32'd0;
            end else begin
                resp_data_s = rdata_s;
            end
            resp_err_s = 1'b0;
        end else begin
            resp_data_s = TIMEOUT_DATA;
            resp_err_s  = 1'b1;
        end
    end

    // Transaction FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_r     <= ST_IDLE;
            prio_r      <= 1'b0;
            grant_r     <= 1'b0;
            cnt_r       <= 16'd0;
            seen_r      <= 1'b0;
            cap_data_r  <= 32'd0;
            api_cs_r    <= 1'b0;
            api_we_r    <= 1'b0;
            api_addr_r  <= 12'd0;
            api_wdata_r <= 32'd0;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            rdata0_r    <= 32'd0;
            rdata1_r    <= 32'd0;
            err0_r      <= 1'b0;
            err1_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        grant_r     <= grant_s;
                        prio_r      <= ~grant_s;
                        api_we_r    <= we_s;
                        api_addr_r  <= addr_s;
                        api_wdata_r <= wdata_s;
                        api_cs_r    <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    api_cs_r   <= 1'b0;
                    cnt_r      <= 16'd0;
                    seen_r     <= 1'b0;
                    cap_data_r <= 32'd0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.i_api_read_data_valid) begin
                        cap_data_r <= bus.i_api_read_data;
                        seen_r     <= 1'b1;
                    end
                    // Normal completion wins over a coincident timeout via resp_*_s.
                    if (done_s || tmo_s) begin
                        if (grant_r) begin
                            ack1_r   <= 1'b1;
                            rdata1_r <= resp_data_s;
                            err1_r   <= resp_err_s;
                        end else begin
                            ack0_r   <= 1'b1;
                            rdata0_r <= resp_data_s;
                            err0_r   <= resp_err_s;
                        end
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r   <= cnt_r + 16'd1;
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    ack0_r  <= 1'b0;
                    ack1_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    api_cs_r <= 1'b0;
                    ack0_r   <= 1'b0;
                    ack1_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_api_cs         = api_cs_r;
    assign bus.o_api_we         = api_we_r;
    assign bus.o_api_address    = api_addr_r;
    assign bus.o_api_write_data = api_wdata_r;
    assign bus.o_req0_ack       = ack0_r;
    assign bus.o_req0_read_data = rdata0_r;
    assign bus.o_req0_error     = err0_r;
    assign bus.o_req1_ack       = ack1_r;
    assign bus.o_req1_read_data = rdata1_r;
    assign bus.o_req1_error     = err1_r;
    assign bus.o_busy           = busy_r;

endmodule

// File: tb/tb_nts_api_arbiter.sv
// Self-checking bench for nts_api_arbiter: directed vector table, multi-cycle
// corner sequences and random traffic against a downstream memory model.
`timescale 1ns/1ps
module tb_nts_api_arbiter;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    nts_api_arbiter_if bus();

    nts_api_arbiter #(
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_DATA  (32'hDEAD_BEEF)
    ) dut (
        .i_clk   (clk),
        .i_areset(areset),
        .bus     (bus)
    );

    typedef struct {
        logic        r;
        logic [31:0] d;
        logic        e;
    } exp_t;

    typedef struct {
        logic        r;
        logic        we;
        logic [11:0] a;
        logic [31:0] wd;
        int          busy_n;
        bit          early;
        bit          respond;
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_lat;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] last_d  [2];
    logic        last_e  [2];

    int n_pass = 0;
    int n_total = 0;
    int viol = 0;
    int api_cs_cnt = 0;
    int txn_cnt = 0;
    logic prev_cs = 1'b0;
    int cfg_busy = 0;
    bit cfg_early = 1'b0;
    bit cfg_respond = 1'b1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive_req(input logic r, input logic cs, input logic we,
                             input logic [11:0] a, input logic [31:0] wd);
        if (r) begin
            bus.i_req1_cs = cs; bus.i_req1_we = we;
            bus.i_req1_address = a; bus.i_req1_write_data = wd;
        end else begin
            bus.i_req0_cs = cs; bus.i_req0_we = we;
            bus.i_req0_address = a; bus.i_req0_write_data = wd;
        end
    endtask

    task automatic clear_expect();
        sb.delete();
        last_d[0] = 32'd0; last_d[1] = 32'd0;
        last_e[0] = 1'b0;  last_e[1] = 1'b0;
    endtask

    // One complete transaction from an IDLE negedge; returns at the next IDLE negedge.
    task automatic do_txn(input logic r, input logic we, input logic [11:0] a, input logic [31:0] wd,
                          input int busy_n, input bit early, input bit respond,
                          input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
        exp_t e;
        int   n;
        bit   got;
        bit   stable;
        e.r = r; e.d = exp_d; e.e = exp_e;
        sb.push_back(e);
        if (we) ref_mem[a] = wd;
        cfg_busy = busy_n; cfg_early = early; cfg_respond = respond;
        drive_req(r, 1'b1, we, a, wd);
        n = 1; got = 1'b0; stable = 1'b1;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.o_api_address !== a || bus.o_api_we !== we || bus.o_api_write_data !== wd) stable = 1'b0;
            if (bus.o_req0_ack || bus.o_req1_ack) begin
                got = 1'b1;
            end else begin
                bus.i_req0_address = 12'($urandom); bus.i_req0_write_data = $urandom;
                bus.i_req1_address = 12'($urandom); bus.i_req1_write_data = $urandom;
            end
        end
        drive_req(r, 1'b0, 1'b0, 12'd0, 32'd0);
        txn_cnt++;
        check("ack_seen", got, 1'b1);
        if (got && exp_lat > 0) check("latency", n, exp_lat);
        check("cmd_stable", stable, 1'b1);
        @(negedge clk);
    endtask

    // Downstream API model: shared memory, configurable busy/valid behaviour.
    initial begin : downstream
        logic        we_l;
        logic [11:0] a_l;
        logic [31:0] wd_l;
        int          b_l;
        bit          e_l;
        bit          rsp_l;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0A00_0000 | 32'(i);
        bus.i_api_busy = 1'b0;
        bus.i_api_read_data_valid = 1'b0;
        bus.i_api_read_data = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.o_api_cs && !areset) begin
                we_l = bus.o_api_we; a_l = bus.o_api_address; wd_l = bus.o_api_write_data;
                b_l = cfg_busy; e_l = cfg_early; rsp_l = cfg_respond;
                if (rsp_l) begin
                    for (int k = 0; k < b_l; k++) begin
                        @(negedge clk);
                        bus.i_api_busy = 1'b1;
                        bus.i_api_read_data_valid = (e_l && k == 0);
                        bus.i_api_read_data = (e_l && k == 0) ? mem[a_l] : (32'hBAD0_0000 | 32'(k));
                    end
                    @(negedge clk);
                    bus.i_api_busy = 1'b0;
                    bus.i_api_read_data_valid = !(e_l && b_l > 0);
                    bus.i_api_read_data = (e_l && b_l > 0) ? 32'hBAD0_FFFF : mem[a_l];
                    if (we_l) mem[a_l] = wd_l;
                    @(negedge clk);
                    bus.i_api_read_data_valid = 1'b0;
                    bus.i_api_read_data = 32'h5A5A_5A5A;
                end
            end
        end
    end

    // Scoreboard and protocol monitor, sampled on the falling edge.
    initial begin : monitor
        exp_t e;
        logic r;
        forever begin
            @(negedge clk);
            if (areset) begin
                prev_cs = 1'b0;
            end else begin
                if (bus.o_req0_ack && bus.o_req1_ack) viol++;
                if (bus.o_api_cs && prev_cs) viol++;
                if (bus.o_api_cs) api_cs_cnt++;
                prev_cs = bus.o_api_cs;
                if (bus.o_req0_ack || bus.o_req1_ack) begin
                    r = bus.o_req1_ack;
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_ack: ack from requester %0d, expected none", r);
                    end else begin
                        e = sb.pop_front();
                        if (r) begin
                            check("resp", {r, bus.o_req1_error, bus.o_req1_read_data}, {e.r, e.e, e.d});
                            check("hold_other", {bus.o_req0_error, bus.o_req0_read_data}, {last_e[0], last_d[0]});
                        end else begin
                            check("resp", {r, bus.o_req0_error, bus.o_req0_read_data}, {e.r, e.e, e.d});
                            check("hold_other", {bus.o_req1_error, bus.o_req1_read_data}, {last_e[1], last_d[1]});
                        end
                        last_d[e.r] = e.d;
                        last_e[e.r] = e.e;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int   snap;
        int   n;
        bit   got;
        logic w;
        logic [11:0] a;
        logic [31:0] wd;
        int   b;

        vecs[0] = '{1'b0, 1'b0, 12'h005, 32'h0,         0, 1'b0, 1'b1, 32'h0A00_0005, 1'b0, 4};
        vecs[1] = '{1'b1, 1'b1, 12'h210, 32'h8000_0010, 3, 1'b0, 1'b1, 32'h0,         1'b0, 7};
        vecs[2] = '{1'b0, 1'b0, 12'h210, 32'h0,         0, 1'b0, 1'b1, 32'h8000_0010, 1'b0, 4};
        vecs[3] = '{1'b1, 1'b0, 12'h3FF, 32'h0,         2, 1'b1, 1'b1, 32'h0A00_03FF, 1'b0, 6};
        vecs[4] = '{1'b0, 1'b1, 12'h005, 32'h1234_5678, 0, 1'b0, 1'b1, 32'h0,         1'b0, 4};
        vecs[5] = '{1'b1, 1'b0, 12'h005, 32'h0,         0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 11};
        vecs[6] = '{1'b1, 1'b0, 12'h005, 32'h0,         1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 5};
        vecs[7] = '{1'b0, 1'b0, 12'hFFF, 32'h0,         0, 1'b0, 1'b1, 32'h0A00_0FFF, 1'b0, 4};

        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0A00_0000 | 32'(i);
        clear_expect();
        areset = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
        drive_req(1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.o_req0_ack, bus.o_req1_ack, bus.o_req0_read_data, bus.o_req1_read_data,
               bus.o_req0_error, bus.o_req1_error, bus.o_api_cs, bus.o_api_we,
               bus.o_api_address, bus.o_api_write_data, bus.o_busy}, 128'd0);
        areset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_cs", {api_cs_cnt, 31'd0, bus.o_busy}, 64'd0);

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].r, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].busy_n, vecs[i].early,
                   vecs[i].respond, vecs[i].exp_d, vecs[i].exp_e, vecs[i].exp_lat);

        // Reset during the third WAIT cycle of a req0 read aborts it without an ack.
        cfg_busy = 5; cfg_early = 1'b0; cfg_respond = 1'b1;
        drive_req(1'b0, 1'b1, 1'b0, 12'h033, 32'd0);
        repeat (4) @(negedge clk);
        check("busy_mid_txn", bus.o_busy, 1'b1);
        areset = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
        clear_expect();
        txn_cnt++;
        #1;
        check("reset_abort_outputs",
              {bus.o_req0_ack, bus.o_req1_ack, bus.o_req0_read_data, bus.o_req1_read_data,
               bus.o_req0_error, bus.o_req1_error, bus.o_api_cs, bus.o_api_we,
               bus.o_api_address, bus.o_api_write_data, bus.o_busy}, 128'd0);
        repeat (8) @(negedge clk);
        areset = 1'b0;
        snap = api_cs_cnt;
        repeat (4) @(negedge clk);
        check("no_cs_after_reset", api_cs_cnt, snap);
        check("idle_after_reset", bus.o_busy, 1'b0);

        // Both requesters assert together four times: grants alternate from requester 0.
        snap = api_cs_cnt;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            w = k[0];
            cfg_busy = 0; cfg_early = 1'b0; cfg_respond = 1'b1;
            e.r = w; e.e = 1'b0;
            e.d = w ? ref_mem[12'h020 + 12'(k)] : ref_mem[12'h010 + 12'(k)];
            sb.push_back(e);
            drive_req(1'b0, 1'b1, 1'b0, 12'h010 + 12'(k), 32'd0);
            drive_req(1'b1, 1'b1, 1'b0, 12'h020 + 12'(k), 32'd0);
            n = 1; got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clk);
                n++;
                got = bus.o_req0_ack | bus.o_req1_ack;
            end
            check("rr_winner", {got, bus.o_req1_ack}, {1'b1, w});
            drive_req(1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
            drive_req(1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
            txn_cnt++;
            @(negedge clk);
        end
        check("rr_cs_count", api_cs_cnt - snap, 4);

        do_txn(1'b1, 1'b0, 12'h0AB, 32'd0, 0, 1'b0, 1'b1, 32'h0A00_00AB, 1'b0, 4);

        // Random writes then reads over 0x200-0x2FF through the shared memory.
        for (int i = 0; i < 256; i++) begin
            a  = 12'h200 + 12'($urandom_range(0, 255));
            wd = $urandom;
            b  = $urandom_range(0, 3);
            do_txn(1'($urandom_range(0, 1)), 1'b1, a, wd, b, 1'b0, 1'b1, 32'd0, 1'b0, 4 + b);
        end
        for (int i = 0; i < 256; i++) begin
            a = 12'h200 + 12'(i);
            b = $urandom_range(0, 3);
            do_txn(1'($urandom_range(0, 1)), 1'b0, a, 32'd0, b, 1'($urandom_range(0, 1)), 1'b1,
                   ref_mem[a], 1'b0, 4 + b);
        end

        repeat (3) @(negedge clk);
        check("protocol_violations", viol, 0);
        check("api_cs_total", api_cs_cnt, txn_cnt);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
